// File: rtl/xnur_arbiter.sv
// xnur_arbiter
// Two-requester arbiter around a 1-bit XNOR unit. One operation is in
// flight at a time: a request accepted in IDLE is granted in EXEC and its
// result is strobed in DONE, giving one operation per three cycles.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous, active-high reset
//   req0     in   requester 0 request
//   a0, b0   in   requester 0 operands
//   req1     in   requester 1 request
//   a1, b1   in   requester 1 operands
//   ready    out  arbiter can accept a request this cycle
//   gnt0     out  one-cycle grant: requester 0 operands captured
//   gnt1     out  one-cycle grant: requester 1 operands captured
//   y_valid  out  one-cycle result strobe
//   y        out  result bit, held outside DONE
//   y_id     out  owner of y, held outside DONE
//
// Build option
//   XNUR_ROUND_ROBIN_EN  when defined, simultaneous requests alternate
//                        between requesters; otherwise requester 0 wins.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | ready; accepts a request, captures winner operands
// EXEC  | grant pulse to owner; result registered at the edge
// DONE  | y_valid pulse; returns to IDLE
module xnur_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic a0,
    input  logic b0,
    input  logic req1,
    input  logic a1,
    input  logic b1,
    output logic ready,
    output logic gnt0,
    output logic gnt1,
    output logic y_valid,
    output logic y,
    output logic y_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_owner;
    logic r_hold_a;
    logic r_hold_b;
    logic r_y;
    logic r_y_id;

    logic w_accept;
    logic w_winner;
    logic w_tie_winner;
    logic w_sel_a;
    logic w_sel_b;

`ifdef XNUR_ROUND_ROBIN_EN
    // Reset value 1 makes requester 0 win the first tie.
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_winner;
        end
    end

    assign w_tie_winner = ~r_last;
`else
    assign w_tie_winner = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && (req0 || req1);
    assign w_winner = (req0 && req1) ? w_tie_winner : req1;
    assign w_sel_a  = w_winner ? a1 : a0;
    assign w_sel_b  = w_winner ? b1 : b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are forced to their idle values while rst is high so that an
    // operation caught by reset in EXEC or DONE emits no pulse.
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        y_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                gnt0        = ~r_owner;
                gnt1        = r_owner;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                y_valid     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (rst) begin
            ready   = 1'b1;
            gnt0    = 1'b0;
            gnt1    = 1'b0;
            y_valid = 1'b0;
        end
    end

    // Capture rule: a=1,b=1 is stored as 0,0; every other pair unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner  <= 1'b0;
            r_hold_a <= 1'b0;
            r_hold_b <= 1'b0;
            r_y      <= 1'b0;
            r_y_id   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner  <= w_winner;
                r_hold_a <= w_sel_a & ~w_sel_b;
                r_hold_b <= w_sel_b & ~w_sel_a;
            end
            if (r_state == S_EXEC) begin
                r_y    <= ~(r_hold_a ^ r_hold_b);
                r_y_id <= r_owner;
            end
        end
    end

    assign y    = r_y;
    assign y_id = r_y_id;

endmodule
